// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared definitions for the dual-clock FIFO controllers:
//                pointer-width helper and binary/Gray conversion functions.
//                The conversions work on the widest legal pointer; callers
//                zero-extend their pointer in and truncate the result out.
//                Zero extension is harmless for both conversions because
//                the extra high bits are all zero.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  localparam int MAX_ADDR_WDTH = 12;
  localparam int MAX_PTR_W     = MAX_ADDR_WDTH + 1;

  typedef logic [MAX_PTR_W-1:0] ptr_max_t;

  // Pointer width: one bit more than the RAM address to tell full from empty.
  function automatic int PTR_W(input int addr_wdth);
    return addr_wdth + 1;
  endfunction

  function automatic ptr_max_t bin2gray(input ptr_max_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic ptr_max_t gray2bin(input ptr_max_t gray);
    ptr_max_t bin;
    bin[MAX_PTR_W-1] = gray[MAX_PTR_W-1];
    for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_ff
//  Description : Generic per-bit multi-flop synchronizer. Each bit of d_i
//                passes through STAGES flops clocked by clk.
//  Ports       : clk          - destination clock
//                rst_n        - asynchronous reset, active-low
//                sync_rst_n_i - synchronous reset, active-low
//                d_i          - asynchronous input vector
//                q_o          - synchronized output vector
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_ff #(
  parameter int WDTH   = 1,
  parameter int STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sync_rst_n_i,
  input  logic [WDTH-1:0] d_i,
  output logic [WDTH-1:0] q_o
);

  // stage_q[0] is the first (metastability-exposed) flop.
  logic [STAGES-1:0][WDTH-1:0] stage_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else if (!sync_rst_n_i) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/async_fifo_wr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : async_fifo_wr_ctrl
//  Description : Write-side controller of the dual-clock FIFO. Keeps the
//                binary/Gray write pointer, synchronizes the read pointer,
//                and produces full, almost-full, fill level, write
//                acknowledge and a sticky overflow flag.
//  Ports       : clk, rst_n       - write clock, async active-low reset
//                sync_rst_n_i     - synchronous active-low reset
//                wr_en_i          - write request
//                rd_ptr_gray_i    - read pointer, Gray, read-clock domain
//                ovf_clr_i        - clear sticky overflow
//                wr_ack_o         - write accepted this cycle (comb)
//                mem_we_o         - RAM write enable (comb)
//                mem_waddr_o      - RAM write address
//                wr_ptr_gray_o    - registered Gray write pointer
//                wr_ptr_bin_o     - registered binary write pointer
//                wr_level_o       - registered fill level
//                full_o           - registered full flag
//                almost_full_o    - registered almost-full flag
//                overflow_o       - sticky: write attempted while full
//  Revision    : 1.0 - initial release
// ============================================================================
module async_fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WDTH    = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sync_rst_n_i,
  input  logic                   wr_en_i,
  input  logic [ADDR_WDTH:0]     rd_ptr_gray_i,
  input  logic                   ovf_clr_i,
  output logic                   wr_ack_o,
  output logic                   mem_we_o,
  output logic [ADDR_WDTH-1:0]   mem_waddr_o,
  output logic [ADDR_WDTH:0]     wr_ptr_gray_o,
  output logic [ADDR_WDTH:0]     wr_ptr_bin_o,
  output logic [ADDR_WDTH:0]     wr_level_o,
  output logic                   full_o,
  output logic                   almost_full_o,
  output logic                   overflow_o
);

  localparam int               P_W       = PTR_W(ADDR_WDTH);
  localparam logic [P_W-1:0]   AFULL_LVL = P_W'(AFULL_THRESH);

  if (ADDR_WDTH < 2 || ADDR_WDTH > MAX_ADDR_WDTH) begin : g_bad_addr_wdth
    $error("async_fifo_wr_ctrl: ADDR_WDTH out of range 2..12");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("async_fifo_wr_ctrl: SYNC_STAGES out of range 2..4");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > (1 << ADDR_WDTH)) begin : g_bad_afull
    $error("async_fifo_wr_ctrl: AFULL_THRESH out of range");
  end

  // Registered state
  logic [P_W-1:0] wr_ptr_bin_q,  wr_ptr_bin_d;
  logic [P_W-1:0] wr_ptr_gray_q, wr_ptr_gray_d;
  logic [P_W-1:0] wr_level_q,    wr_level_d;
  logic           full_q,        full_d;
  logic           almost_full_q, almost_full_d;
  logic           overflow_q,    overflow_d;

  // Combinational
  logic           wr_ack;
  logic [P_W-1:0] rq;        // synchronized read pointer, Gray
  logic [P_W-1:0] rbin;      // synchronized read pointer, binary
  logic [P_W-1:0] rq_full;   // Gray value the write pointer has when full

  sync_ff #(
    .WDTH   (P_W),
    .STAGES (SYNC_STAGES)
  ) u_rd_ptr_sync (
    .clk          (clk),
    .rst_n        (rst_n),
    .sync_rst_n_i (sync_rst_n_i),
    .d_i          (rd_ptr_gray_i),
    .q_o          (rq)
  );

  always_comb begin
    wr_ack        = wr_en_i & ~full_q;
    rbin          = P_W'(gray2bin(ptr_max_t'(rq)));
    wr_ptr_bin_d  = wr_ptr_bin_q + P_W'(wr_ack);
    wr_ptr_gray_d = P_W'(bin2gray(ptr_max_t'(wr_ptr_bin_d)));
    // Full when the write pointer is exactly one lap ahead: in Gray that is
    // the read pointer with its top two bits inverted.
    rq_full       = {~rq[P_W-1:P_W-2], rq[P_W-3:0]};
    full_d        = (wr_ptr_gray_d == rq_full);
    wr_level_d    = wr_ptr_bin_d - rbin;
    almost_full_d = (wr_level_d >= AFULL_LVL);
    // Set has priority over clear.
    overflow_d    = (wr_en_i & full_q) | (overflow_q & ~ovf_clr_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_bin_q  <= '0;
      wr_ptr_gray_q <= '0;
      wr_level_q    <= '0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else if (!sync_rst_n_i) begin
      wr_ptr_bin_q  <= '0;
      wr_ptr_gray_q <= '0;
      wr_level_q    <= '0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      wr_ptr_bin_q  <= wr_ptr_bin_d;
      wr_ptr_gray_q <= wr_ptr_gray_d;
      wr_level_q    <= wr_level_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
    end
  end

  assign wr_ack_o      = wr_ack;
  assign mem_we_o      = wr_ack;
  assign mem_waddr_o   = wr_ptr_bin_q[ADDR_WDTH-1:0];
  assign wr_ptr_gray_o = wr_ptr_gray_q;
  assign wr_ptr_bin_o  = wr_ptr_bin_q;
  assign wr_level_o    = wr_level_q;
  assign full_o        = full_q;
  assign almost_full_o = almost_full_q;
  assign overflow_o    = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_async_fifo_wr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_async_fifo_wr_ctrl
//  Description : Self-checking bench for async_fifo_wr_ctrl. A cycle model
//                pushes expected register values at every clock edge; a
//                checker pops and compares them just after the edge.
//                Scenario tasks add directed checks of their own.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_async_fifo_wr_ctrl;

  localparam int AW  = 4;
  localparam int SS  = 2;
  localparam int THR = 12;
  localparam int P_W = AW + 1;
  localparam logic [P_W-1:0] DEPTH_V = P_W'(1 << AW);
  localparam logic [P_W-1:0] THR_V   = P_W'(THR);

  logic           clk = 1'b0;
  logic           rst_n;
  logic           sync_rst_n;
  logic           wr_en;
  logic [P_W-1:0] rd_ptr_gray;
  logic           ovf_clr;
  logic           wr_ack, mem_we;
  logic [AW-1:0]  mem_waddr;
  logic [P_W-1:0] wr_ptr_gray, wr_ptr_bin, wr_level;
  logic           full, almost_full, overflow;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  async_fifo_wr_ctrl #(
    .ADDR_WDTH    (AW),
    .SYNC_STAGES  (SS),
    .AFULL_THRESH (THR)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sync_rst_n_i  (sync_rst_n),
    .wr_en_i       (wr_en),
    .rd_ptr_gray_i (rd_ptr_gray),
    .ovf_clr_i     (ovf_clr),
    .wr_ack_o      (wr_ack),
    .mem_we_o      (mem_we),
    .mem_waddr_o   (mem_waddr),
    .wr_ptr_gray_o (wr_ptr_gray),
    .wr_ptr_bin_o  (wr_ptr_bin),
    .wr_level_o    (wr_level),
    .full_o        (full),
    .almost_full_o (almost_full),
    .overflow_o    (overflow)
  );

  // ---------------------------------------------------------------- model
  typedef struct packed {
    logic [P_W-1:0] bin;
    logic [P_W-1:0] gray;
    logic [P_W-1:0] level;
    logic           full;
    logic           afull;
    logic           ovf;
  } exp_t;

  exp_t           sb_q[$];
  logic [P_W-1:0] m_sync [SS];
  logic [P_W-1:0] m_bin, m_nb, m_rb, m_level;
  logic           m_full, m_afull, m_ovf, m_ack, m_full_old;

  function automatic logic [P_W-1:0] gray_of(input int v);
    logic [P_W-1:0] t;
    t = v[P_W-1:0];
    return t ^ (t >> 1);
  endfunction

  always @(posedge clk) begin : p_model
    if (!rst_n || !sync_rst_n) begin
      m_bin = '0; m_level = '0; m_full = 1'b0; m_afull = 1'b0; m_ovf = 1'b0;
      for (int s = 0; s < SS; s++) m_sync[s] = '0;
    end else begin
      m_full_old = m_full;
      m_ack      = wr_en & ~m_full;
      m_nb       = m_bin + P_W'(m_ack);
      m_rb[P_W-1] = m_sync[SS-1][P_W-1];
      for (int b = P_W - 2; b >= 0; b--) m_rb[b] = m_rb[b+1] ^ m_sync[SS-1][b];
      m_level = m_nb - m_rb;
      m_full  = (m_level == DEPTH_V);
      m_afull = (m_level >= THR_V);
      m_ovf   = (wr_en & m_full_old) | (m_ovf & ~ovf_clr);
      m_bin   = m_nb;
      for (int s = SS - 1; s > 0; s--) m_sync[s] = m_sync[s-1];
      m_sync[0] = rd_ptr_gray;
    end
    sb_q.push_back('{m_bin, gray_of(int'(m_bin)), m_level, m_full, m_afull, m_ovf});
  end

  always @(posedge clk) begin : p_check
    exp_t e;
    exp_t got;
    logic ackx;
    #1;
    tests_run++;
    if (sb_q.size() == 0) begin
      tests_failed++;
      $display("FAIL sb_empty: no expected entry at %0t", $time);
    end else begin
      e   = sb_q.pop_front();
      got = '{wr_ptr_bin, wr_ptr_gray, wr_level, full, almost_full, overflow};
      if (got !== e) begin
        tests_failed++;
        $display("FAIL sb_regs @%0t: got bin=%h gray=%h lvl=%h f=%b af=%b ovf=%b, exp bin=%h gray=%h lvl=%h f=%b af=%b ovf=%b",
                 $time, got.bin, got.gray, got.level, got.full, got.afull, got.ovf,
                 e.bin, e.gray, e.level, e.full, e.afull, e.ovf);
      end
      ackx = wr_en & ~e.full;
      tests_run++;
      if ({wr_ack, mem_we, mem_waddr} !== {ackx, ackx, e.bin[AW-1:0]}) begin
        tests_failed++;
        $display("FAIL sb_comb @%0t: got ack=%b we=%b waddr=%h, exp ack=%b we=%b waddr=%h",
                 $time, wr_ack, mem_we, mem_waddr, ackx, ackx, e.bin[AW-1:0]);
      end
    end
  end

  // ------------------------------------------------------------- scenarios
  task automatic test_reset();
    rst_n = 1'b0; sync_rst_n = 1'b1; wr_en = 1'b0; rd_ptr_gray = '0; ovf_clr = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({wr_ptr_bin, wr_ptr_gray, wr_level, full, almost_full, overflow, wr_ack, mem_we} !== '0) begin
      tests_failed++;
      $display("FAIL reset_values: got bin=%h gray=%h lvl=%h f=%b af=%b ovf=%b ack=%b we=%b, exp all 0",
               wr_ptr_bin, wr_ptr_gray, wr_level, full, almost_full, overflow, wr_ack, mem_we);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    int acks = 0;
    @(negedge clk);
    rd_ptr_gray = '0; wr_en = 1'b1;
    for (int i = 0; i < 17; i++) begin
      #1;
      acks += int'(wr_ack);
      if (i == 15 || i == 16) begin
        tests_run++;
        if (full !== (i == 16)) begin
          tests_failed++;
          $display("FAIL fill_full_timing i=%0d: got full=%b exp %b", i, full, (i == 16));
        end
      end
      @(negedge clk);
    end
    wr_en = 1'b0;
    tests_run++;
    if (acks != 16) begin
      tests_failed++;
      $display("FAIL fill_ack_count: got %0d exp 16", acks);
    end
    tests_run++;
    if ({wr_ptr_bin, wr_ptr_gray, wr_level} !== {5'b10000, 5'b11000, 5'd16}) begin
      tests_failed++;
      $display("FAIL fill_ptrs: got bin=%b gray=%b lvl=%0d exp 10000 11000 16",
               wr_ptr_bin, wr_ptr_gray, wr_level);
    end
    tests_run++;
    if ({full, almost_full, overflow} !== 3'b111) begin
      tests_failed++;
      $display("FAIL fill_flags: got f/af/ovf=%b%b%b exp 111", full, almost_full, overflow);
    end
  endtask

  task automatic test_ovf_clear();
    wr_en = 1'b1; ovf_clr = 1'b1;
    @(negedge clk);
    tests_run++;
    if (overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_set_wins: got ovf=%b exp 1", overflow);
    end
    wr_en = 1'b0;
    @(negedge clk);
    tests_run++;
    if (overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_clear: got ovf=%b exp 0", overflow);
    end
    ovf_clr = 1'b0;
  endtask

  task automatic test_full_release();
    rd_ptr_gray = 5'b00001;
    for (int k = 1; k <= SS + 1; k++) begin
      @(negedge clk);
      tests_run++;
      if ({full, wr_level} !== {(k <= SS), (k <= SS) ? 5'd16 : 5'd15}) begin
        tests_failed++;
        $display("FAIL release_edge%0d: got full=%b lvl=%0d exp full=%b lvl=%0d",
                 k, full, wr_level, (k <= SS), (k <= SS) ? 16 : 15);
      end
    end
    wr_en = 1'b1;
    #1;
    tests_run++;
    if (wr_ack !== 1'b1) begin
      tests_failed++;
      $display("FAIL release_accept: got ack=%b exp 1", wr_ack);
    end
    @(negedge clk);
    wr_en = 1'b0;
    tests_run++;
    if ({wr_ptr_bin, full} !== {5'd17, 1'b1}) begin
      tests_failed++;
      $display("FAIL release_refill: got bin=%0d full=%b exp 17 1", wr_ptr_bin, full);
    end
  endtask

  task automatic test_sync_reset();
    wr_en = 1'b1;                       // attempt while full sets overflow
    @(negedge clk);
    wr_en = 1'b0;
    rd_ptr_gray = gray_of(10);          // read pointer 10, write 17 -> level 7
    repeat (SS + 1) @(negedge clk);
    tests_run++;
    if ({wr_level, overflow} !== {5'd7, 1'b1}) begin
      tests_failed++;
      $display("FAIL srst_setup: got lvl=%0d ovf=%b exp 7 1", wr_level, overflow);
    end
    sync_rst_n = 1'b0; rd_ptr_gray = '0;
    @(negedge clk);
    sync_rst_n = 1'b1;
    tests_run++;
    if ({wr_ptr_bin, wr_ptr_gray, wr_level, full, almost_full, overflow} !== '0) begin
      tests_failed++;
      $display("FAIL srst_values: got bin=%h gray=%h lvl=%h f=%b af=%b ovf=%b exp all 0",
               wr_ptr_bin, wr_ptr_gray, wr_level, full, almost_full, overflow);
    end
  endtask

  task automatic test_afull();
    wr_en = 1'b1;
    repeat (11) @(negedge clk);
    wr_en = 1'b0;
    tests_run++;
    if ({almost_full, wr_level} !== {1'b0, 5'd11}) begin
      tests_failed++;
      $display("FAIL afull_11: got af=%b lvl=%0d exp 0 11", almost_full, wr_level);
    end
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    tests_run++;
    if ({almost_full, wr_level, full} !== {1'b1, 5'd12, 1'b0}) begin
      tests_failed++;
      $display("FAIL afull_12: got af=%b lvl=%0d f=%b exp 1 12 0", almost_full, wr_level, full);
    end
  endtask

  task automatic test_wrap();
    logic [P_W-1:0] prev_b, prev_g, step;
    int bad_step = 0, bad_gray = 0, wrap_ok = 0, full_seen = 0;
    sync_rst_n = 1'b0; rd_ptr_gray = '0;
    @(negedge clk);
    sync_rst_n = 1'b1;
    prev_b = wr_ptr_bin; prev_g = wr_ptr_gray;
    for (int i = 0; i < 40; i++) begin
      wr_en = 1'b1;
      rd_ptr_gray = gray_of((i >= 3) ? i - 3 : 0);
      @(negedge clk);
      step = wr_ptr_bin - prev_b;
      if (step !== 5'd1) bad_step++;
      if ($countones(wr_ptr_gray ^ prev_g) != 1) bad_gray++;
      if (prev_b == 5'd31 && wr_ptr_bin == 5'd0 && prev_g == 5'b10000 && wr_ptr_gray == 5'b00000)
        wrap_ok++;
      if (full !== 1'b0) full_seen++;
      prev_b = wr_ptr_bin; prev_g = wr_ptr_gray;
    end
    wr_en = 1'b0;
    tests_run++;
    if (bad_step != 0 || bad_gray != 0) begin
      tests_failed++;
      $display("FAIL wrap_steps: got bad_step=%0d bad_gray=%0d exp 0 0", bad_step, bad_gray);
    end
    tests_run++;
    if (wrap_ok != 1 || wr_ptr_bin !== 5'd8) begin
      tests_failed++;
      $display("FAIL wrap_seen: got wraps=%0d final_bin=%0d exp 1 8", wrap_ok, wr_ptr_bin);
    end
    tests_run++;
    if (full_seen != 0) begin
      tests_failed++;
      $display("FAIL wrap_no_full: got full cycles=%0d exp 0", full_seen);
    end
  endtask

  initial begin : p_watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : p_main
    test_reset();
    test_fill();
    test_ovf_clear();
    test_full_release();
    test_sync_reset();
    test_afull();
    test_wrap();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
